// File: rtl/conv_engine.sv
// conv_engine: loads a 4x4 image of 4-bit pixels, then computes four 3x3
// (stride 1) and four 2x2 (stride 2) convolutions with one multiply-accumulate
// per cycle. Results are saturated to 8 bits and published atomically on done.
//
// Pixel handshake: a pixel transfers on a rising clk edge where
// pix_valid && pix_ready. pix_ready is high for the whole LOAD state and low
// elsewhere, so pix_valid outside LOAD has no effect. The source may drop
// pix_valid for any number of cycles.
module conv_engine #(
  parameter logic [35:0] K9 = 36'h111111111,
  parameter logic [15:0] K4 = 16'h1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [3:0] pix_in,
  output logic       pix_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] c9_11,
  output logic [7:0] c9_12,
  output logic [7:0] c9_21,
  output logic [7:0] c9_22,
  output logic [7:0] c4_11,
  output logic [7:0] c4_12,
  output logic [7:0] c4_21,
  output logic [7:0] c4_22,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pix_cnt_q, pix_cnt_d;
  logic [3:0]  img_q [16];
  logic [3:0]  img_d [16];
  logic [2:0]  res_q, res_d;      // result index: 0..3 are c9, 4..7 are c4
  logic [1:0]  ti_q, ti_d;        // kernel tap row
  logic [1:0]  tj_q, tj_d;        // kernel tap column
  logic [11:0] acc_q, acc_d;
  logic [7:0]  shd_q [8];
  logic [7:0]  shd_d [8];
  logic [7:0]  out_q [8];
  logic [7:0]  out_d [8];

  logic        accept;
  logic        is4;
  logic [1:0]  last_k;
  logic [1:0]  row_base, col_base;
  logic [1:0]  pix_row, pix_col;
  logic [3:0]  pix_idx;
  logic [3:0]  w9_idx;
  logic [1:0]  w4_idx;
  logic [3:0]  weight;
  logic [7:0]  product;
  logic        tap_first, tap_last;
  logic [11:0] acc_sum;
  logic [7:0]  acc_sat;

  // Tap addressing and the single multiply-accumulate of the current cycle
  always_comb begin
    accept    = (state_q == LOAD) && pix_valid;
    is4       = res_q[2];
    last_k    = is4 ? 2'd1 : 2'd2;
    row_base  = is4 ? {res_q[1], 1'b0} : {1'b0, res_q[1]};
    col_base  = is4 ? {res_q[0], 1'b0} : {1'b0, res_q[0]};
    pix_row   = row_base + ti_q;
    pix_col   = col_base + tj_q;
    pix_idx   = {pix_row, pix_col};
    w9_idx    = ({2'b00, ti_q} << 1) + {2'b00, ti_q} + {2'b00, tj_q};
    w4_idx    = {ti_q[0], tj_q[0]};
    weight    = is4 ? K4[{w4_idx, 2'b00} +: 4] : K9[{w9_idx, 2'b00} +: 4];
    product   = weight * img_q[pix_idx];
    tap_first = (ti_q == 2'd0) && (tj_q == 2'd0);
    tap_last  = (ti_q == last_k) && (tj_q == last_k);
    acc_sum   = (tap_first ? 12'd0 : acc_q) + {4'd0, product};
    acc_sat   = (|acc_sum[11:8]) ? 8'hFF : acc_sum[7:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (accept && (pix_cnt_q == 4'd15)) state_d = CALC;
      CALC: if (tap_last && (res_q == 3'd7)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    pix_ready = (state_q == LOAD);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath next values: pixel capture, tap walk, accumulate, shadow and publish
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    img_d     = img_q;
    res_d     = res_q;
    ti_d      = ti_q;
    tj_d      = tj_q;
    acc_d     = acc_q;
    shd_d     = shd_q;
    out_d     = out_q;
    if ((state_q == IDLE) && start) begin
      pix_cnt_d = 4'd0;
      res_d     = 3'd0;
      ti_d      = 2'd0;
      tj_d      = 2'd0;
    end
    if (accept) begin
      img_d[pix_cnt_q] = pix_in;
      pix_cnt_d        = pix_cnt_q + 4'd1;
    end
    if (state_q == CALC) begin
      acc_d = acc_sum;
      if (tj_q == last_k) begin
        tj_d = 2'd0;
        if (ti_q == last_k) begin
          ti_d         = 2'd0;
          shd_d[res_q] = acc_sat;
          res_d        = res_q + 3'd1;
        end else begin
          ti_d = ti_q + 2'd1;
        end
      end else begin
        tj_d = tj_q + 2'd1;
      end
    end
    // The last result lands in shd_d on the same edge, so publish from shd_d
    if ((state_q == CALC) && (state_d == DONE)) out_d = shd_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q <= 4'd0;
      res_q     <= 3'd0;
      ti_q      <= 2'd0;
      tj_q      <= 2'd0;
      acc_q     <= 12'd0;
      for (int k = 0; k < 16; k++) img_q[k] <= 4'd0;
      for (int k = 0; k < 8; k++) begin
        shd_q[k] <= 8'd0;
        out_q[k] <= 8'd0;
      end
    end else begin
      pix_cnt_q <= pix_cnt_d;
      res_q     <= res_d;
      ti_q      <= ti_d;
      tj_q      <= tj_d;
      acc_q     <= acc_d;
      img_q     <= img_d;
      shd_q     <= shd_d;
      out_q     <= out_d;
    end
  end

  assign c9_11 = out_q[0];
  assign c9_12 = out_q[1];
  assign c9_21 = out_q[2];
  assign c9_22 = out_q[3];
  assign c4_11 = out_q[4];
  assign c4_12 = out_q[5];
  assign c4_21 = out_q[6];
  assign c4_22 = out_q[7];

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: three instances (default, all-max and mixed kernels)
// share one stimulus stream; a loop-based convolution model supplies the
// expected results per frame.
module tb_conv_engine;

  localparam logic [35:0] K9_DEF = 36'h111111111;
  localparam logic [15:0] K4_DEF = 16'h1111;
  localparam logic [35:0] K9_MAX = 36'hFFFFFFFFF;
  localparam logic [15:0] K4_MAX = 16'hFFFF;
  localparam logic [35:0] K9_MIX = 36'h3A5F0C719;
  localparam logic [15:0] K4_MIX = 16'h9E27;

  logic       clk = 1'b0;
  logic       reset, start, pix_valid;
  logic [3:0] pix_in;
  logic       rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2;
  logic [1:0] st0, st1, st2;
  logic [7:0] o0 [8];
  logic [7:0] o1 [8];
  logic [7:0] o2 [8];
  logic [7:0] cur [24];
  logic [7:0] held [24];
  logic [3:0] img [16];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;
  int         hold_err;
  int         rdy_err;

  // clock / reset block
  always #5 clk = ~clk;

  conv_engine #(.K9(K9_DEF), .K4(K4_DEF)) dut0 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(rdy0), .busy(busy0), .done(done0),
    .c9_11(o0[0]), .c9_12(o0[1]), .c9_21(o0[2]), .c9_22(o0[3]),
    .c4_11(o0[4]), .c4_12(o0[5]), .c4_21(o0[6]), .c4_22(o0[7]), .dbg_state(st0));

  conv_engine #(.K9(K9_MAX), .K4(K4_MAX)) dut1 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(rdy1), .busy(busy1), .done(done1),
    .c9_11(o1[0]), .c9_12(o1[1]), .c9_21(o1[2]), .c9_22(o1[3]),
    .c4_11(o1[4]), .c4_12(o1[5]), .c4_21(o1[6]), .c4_22(o1[7]), .dbg_state(st1));

  conv_engine #(.K9(K9_MIX), .K4(K4_MIX)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(rdy2), .busy(busy2), .done(done2),
    .c9_11(o2[0]), .c9_12(o2[1]), .c9_21(o2[2]), .c9_22(o2[3]),
    .c4_11(o2[4]), .c4_12(o2[5]), .c4_21(o2[6]), .c4_22(o2[7]), .dbg_state(st2));

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      cur[k]      = o0[k];
      cur[8 + k]  = o1[k];
      cur[16 + k] = o2[k];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: direct convolution over the image, saturated to 8 bits
  task automatic model_push(input logic [35:0] k9, input logic [15:0] k4);
    int s;
    for (int rc = 0; rc < 4; rc++) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += int'(k9[4*(3*i+j) +: 4]) * int'(img[4*(rc/2+i) + (rc%2+j)]);
      exp_q.push_back((s > 255) ? 8'd255 : 8'(s));
    end
    for (int rc = 0; rc < 4; rc++) begin
      s = 0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          s += int'(k4[4*(2*i+j) +: 4]) * int'(img[4*(2*(rc/2)+i) + (2*(rc%2)+j)]);
      exp_q.push_back((s > 255) ? 8'd255 : 8'(s));
    end
  endtask

  task automatic model_frame();
    model_push(K9_DEF, K4_DEF);
    model_push(K9_MAX, K4_MAX);
    model_push(K9_MIX, K4_MIX);
  endtask

  task automatic check_hold();
    for (int k = 0; k < 24; k++) if (cur[k] !== held[k]) hold_err++;
  endtask

  task automatic check_zero(input string tag);
    int nz;
    nz = 0;
    for (int k = 0; k < 24; k++) if (cur[k] !== 8'd0) nz++;
    chk({tag, "_outs_zero"}, nz, 0);
    chk({tag, "_busy"}, int'(busy0), 0);
    chk({tag, "_done"}, int'(done0), 0);
    chk({tag, "_ready"}, int'(rdy0), 0);
  endtask

  // Driver: called at a negedge; raises start and streams the 16 pixels
  task automatic send_frame(input bit gaps, input bit valid_with_start);
    int n, idx, cyc;
    bit v;
    for (int k = 0; k < 24; k++) held[k] = cur[k];
    hold_err = 0;
    rdy_err  = 0;
    start     = 1'b1;
    pix_valid = valid_with_start;
    pix_in    = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      check_hold();
      n++;
    end while (!rdy0 && n < 10);
    start     = 1'b0;
    chk("enter_load", int'(rdy0), 1);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = v;
      pix_in    = img[idx];
      if (!rdy0) rdy_err++;
      @(negedge clk);
      if (v) idx++;
      check_hold();
      cyc++;
    end
    pix_valid = 1'b0;
    chk("load_count", idx, 16);
    chk("ready_in_load", rdy_err, 0);
    chk("ready_low_calc", int'(rdy0), 0);
    chk("busy_calc", int'(busy0), 1);
  endtask

  // Waits for done (first negedge after the last accept is cycle 1)
  task automatic run_calc(input bit disturb);
    int cyc;
    cyc = 1;
    while (!done0 && cyc < 200) begin
      if (disturb) begin
        start     = 1'($urandom_range(0, 1));
        pix_valid = 1'($urandom_range(0, 1));
        pix_in    = 4'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (!done0) check_hold();
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    chk("done_seen", int'(done0), 1);
    chk("done_latency", cyc, 53);
    chk("done_all_inst", int'({done1, done2}), 3);
    chk("hold_until_done", hold_err, 0);
    chk("exp_q_depth", exp_q.size(), 24);
    for (int k = 0; k < 24; k++) begin
      if (exp_q.size() > 0) chk($sformatf("out%0d", k), int'(cur[k]), int'(exp_q.pop_front()));
    end
    exp_q.delete();
    for (int k = 0; k < 24; k++) held[k] = cur[k];
    hold_err = 0;
  endtask

  task automatic after_done();
    @(negedge clk);
    check_hold();
    chk("done_pulse_width", int'(done0), 0);
    chk("idle_after_done", int'(busy0), 0);
    chk("hold_after_done", hold_err, 0);
  endtask

  task automatic check_const(input string tag, input int a0, input int a1, input int a2,
                             input int a3, input int b0, input int b1, input int b2, input int b3,
                             input bit use_max);
    int e [8];
    e = '{a0, a1, a2, a3, b0, b1, b2, b3};
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_%0d", tag, k), int'(use_max ? o1[k] : o0[k]), e[k]);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("reset");

    // pix_valid alone in IDLE does nothing
    pix_valid = 1'b1;
    repeat (5) @(negedge clk);
    pix_valid = 1'b0;
    chk("stay_idle", int'(busy0), 0);

    // frame A: pixels 0..15, pix_valid also high on the start cycle
    for (int k = 0; k < 16; k++) img[k] = 4'(k);
    model_frame();
    send_frame(1'b0, 1'b1);
    run_calc(1'b0);
    check_const("ramp", 45, 54, 81, 90, 10, 18, 42, 50, 1'b0);
    after_done();

    // frame B: random pixels, gappy valid, start/pix_valid noise during CALC
    for (int k = 0; k < 16; k++) img[k] = 4'($urandom);
    model_frame();
    send_frame(1'b1, 1'b0);
    run_calc(1'b1);
    after_done();

    // frame C: all 15 saturates the max-kernel instance
    for (int k = 0; k < 16; k++) img[k] = 4'd15;
    model_frame();
    send_frame(1'b0, 1'b0);
    run_calc(1'b0);
    check_const("max", 255, 255, 255, 255, 255, 255, 255, 255, 1'b1);
    after_done();

    // abort after 8 pixels
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pix_valid = 1'b1;
      pix_in    = 4'($urandom);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("abort");
    dcnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done0) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);

    // frame of all 1s after the abort
    for (int k = 0; k < 16; k++) img[k] = 4'd1;
    model_frame();
    send_frame(1'b1, 1'b0);
    run_calc(1'b0);
    check_const("ones", 9, 9, 9, 9, 4, 4, 4, 4, 1'b0);

    // start held from the DONE cycle: only seen once back in IDLE
    for (int k = 0; k < 16; k++) img[k] = 4'($urandom);
    model_frame();
    start = 1'b1;
    @(negedge clk);
    chk("restart_in_idle", int'(busy0), 0);
    chk("restart_done_low", int'(done0), 0);
    send_frame(1'b1, 1'b0);
    run_calc(1'b1);
    after_done();

    // one more random back-to-back frame
    for (int k = 0; k < 16; k++) img[k] = 4'($urandom);
    model_frame();
    send_frame(1'b0, 1'b0);
    run_calc(1'b0);
    after_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter K9, 36'h111111111, 3x3 kernel; weight (i,j) unsigned 4-bit at bits [4*(3i+j)+3 : 4*(3i+j)], i = row, j = column.
REQ-002 Parameter K4, 16'h1111, 2x2 kernel; weight (i,j) unsigned 4-bit at bits [4*(2i+j)+3 : 4*(2i+j)].
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  requests a new frame; sampled only in IDLE.
REQ-006 pix_valid  input  1  pix_in holds a valid pixel.
REQ-007 pix_in  input  4  unsigned pixel, raster order (index = 4*row + col) over a 4x4 image P.
REQ-008 pix_ready  output  1  high only in LOAD.
REQ-009 busy  output  1  high in LOAD, CALC and DONE.
REQ-010 done  output  1  one-cycle pulse; results valid from this cycle onward.
REQ-011 c9_11, c9_12, c9_21, c9_22  output  8 each  3x3 convolution results (stride 1, no padding).
REQ-012 c4_11, c4_12, c4_21, c4_22  output  8 each  2x2 convolution results (stride 2).

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, CALC and DONE.
- IDLE -> LOAD on start.
- LOAD -> CALC on the 16th accepted pixel.
- CALC -> DONE after 52 cycles.
- DONE -> IDLE unconditionally.
REQ-014 A pixel SHALL be accepted on an edge where pix_valid && pix_ready; the pixel index counter increments 0..15; pix_valid outside LOAD SHALL be ignored.
REQ-015 LOAD SHALL wait indefinitely for pix_valid, with no timeout.
REQ-016 c9_rc (r,c in {1,2}) SHALL equal the sum over i,j = 0..2 of K9(i,j) * P[r-1+i][c-1+j].
REQ-017 c4_rc SHALL equal the sum over i,j = 0..1 of K4(i,j) * P[2(r-1)+i][2(c-1)+j].
REQ-018 CALC SHALL perform one multiply-accumulate per cycle, in this order:
- c9_11, c9_12, c9_21, c9_22, each with taps (0,0)..(2,2) raster;
- then c4_11..c4_22, each with taps (0,0)..(1,1);
- total 36 + 16 = 52 cycles.
REQ-019 The accumulator SHALL be at least 12 bits unsigned (maximum sum 2025); it clears at the start of each result.
REQ-020 Each finished sum SHALL be saturated to 255 if it exceeds 255, then stored in an internal shadow register.
REQ-021 All eight output registers SHALL load from the shadow registers on the edge entering DONE, the same edge on which done rises; outputs never show a partial frame.
REQ-022 Latency SHALL be as follows:
- the first CALC cycle immediately follows the 16th accept;
- done is high in the 53rd cycle after that accept edge.
REQ-023 Outputs SHALL hold their values until the next DONE, including while a new frame is loading.
REQ-024 start asserted in any state other than IDLE SHALL be ignored; start held high in DONE SHALL NOT be seen until IDLE, so the earliest restart is the cycle after DONE.
REQ-025 start and pix_valid in the same IDLE cycle SHALL transition to LOAD without accepting that pixel.

Reset
REQ-026 While reset is high at posedge clk, the block SHALL enter IDLE, clear the pixel and tap counters, the accumulator and all shadow registers, and drive all c9_*/c4_* = 0, done = 0, busy = 0, pix_ready = 0.
REQ-027 Reset asserted mid-LOAD or mid-CALC SHALL abort the frame; no done pulse is produced and outputs read 0.
REQ-028 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-029 Default kernels, pixels 0..15 streamed back-to-back -> done once in the 53rd cycle after the last accept; c9 = 45, 54, 81, 90; c4 = 10, 18, 42, 50.
REQ-030 K9 = 36'hFFFFFFFFF, K4 = 16'hFFFF, all pixels 15 -> all eight outputs = 255 (saturated from 2025 and 900).
REQ-031 pix_valid toggling randomly during LOAD -> same results as REQ-029; pix_ready stays high throughout LOAD; exactly 16 pixels accepted.
REQ-032 Reset pulsed after 8 pixels, then a new start and full frame of all 1s with default kernels -> no done before the restart; then c9 = 9 each, c4 = 4 each.
REQ-033 start re-pulsed during CALC, and pix_valid high in IDLE -> ignored; one done per frame; outputs unchanged until that done.
REQ-034 Two frames back-to-back, the second loaded while the first results are held -> first-frame values stable until the second done; then they change in a single cycle.
